// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if: instruction-memory req/ack fetch bus.
// master = fetch unit, slave = instruction memory.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC owner and imem fetch FSM (FETCH -> WAIT -> ISSUE).
// Define FETCH_TIMEOUT_EN to abort fetches that see no ack within TIMEOUT cycles.
module instr_fetch_unit #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               PC_sel,
  input  logic               PC_lden,
  input  logic               instr_done,
  instr_fetch_unit_if.master imem,
  output logic [31:0]        instr,
  output logic               instr_valid,
  output logic [31:0]        pc_out,
  output logic               fetch_err
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_ISSUE
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        valid_q, valid_d;
  logic        req_q, req_d;
  logic [31:0] br_off, next_pc;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("TIMEOUT must be at least 1");
  end

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Branch offset is a signed word offset relative to pc+4.
  assign br_off  = PC_sel ?
                   {{14{instr_q[15]}}, instr_q[15:0], 2'b00} :
                   32'h0;
  assign next_pc = pc_q + 32'd4 + br_off;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    req_d   = req_q;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = '0;
    err_d   = err_q;
`endif
    unique case (state_q)
      S_FETCH: begin
        req_d   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_ack) begin
          instr_d = imem.imem_rdata;
          valid_d = 1'b1;
          req_d   = 1'b0;
          state_d = S_ISSUE;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          instr_d = 32'h0;
          valid_d = 1'b1;
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = S_ISSUE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_ISSUE: begin
        if (instr_done) begin
          valid_d = 1'b0;
          if (PC_lden) pc_d = next_pc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      pc_q    <= PC_RESET;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
      req_q   <= req_d;
`ifdef FETCH_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign instr          = instr_q;
  assign instr_valid    = valid_q;
  assign pc_out         = pc_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_err      = err_q;
`else
  assign fetch_err      = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit.
// dut0 resets to 0, dut1 resets to 0xFFFF_FFFC for wrap checks.
module tb_instr_fetch_unit;
  logic        clk = 1'b0;
  logic        reset;
  logic        PC_sel, PC_lden, instr_done;
  logic [31:0] instr, pc_out;
  logic        instr_valid, fetch_err;

  logic        w_reset;
  logic        w_sel, w_lden, w_done;
  logic [31:0] w_instr, w_pc;
  logic        w_valid, w_err;

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;

  exp_t sb[$];

  instr_fetch_unit_if bus ();
  instr_fetch_unit_if wbus ();

  instr_fetch_unit #(
    .PC_RESET (32'h0000_0000),
    .TIMEOUT  (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .PC_sel      (PC_sel),
    .PC_lden     (PC_lden),
    .instr_done  (instr_done),
    .imem        (bus),
    .instr       (instr),
    .instr_valid (instr_valid),
    .pc_out      (pc_out),
    .fetch_err   (fetch_err)
  );

  instr_fetch_unit #(
    .PC_RESET (32'hFFFF_FFFC),
    .TIMEOUT  (16)
  ) dut_wrap (
    .clk         (clk),
    .reset       (w_reset),
    .PC_sel      (w_sel),
    .PC_lden     (w_lden),
    .instr_done  (w_done),
    .imem        (wbus),
    .instr       (w_instr),
    .instr_valid (w_valid),
    .pc_out      (w_pc),
    .fetch_err   (w_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want $finish");
    $fatal(1, "watchdog");
  end

  task automatic pop_exp(output exp_t e);
    if (sb.size() != 0) e = sb.pop_front();
    else e = '{pc: 32'hFFFF_FFFF, word: 32'hFFFF_FFFF};
  endtask

  task automatic serve(input logic [31:0] word, input logic [31:0] exp_pc,
                       input int lat, output bit ok,
                       output logic [31:0] addr);
    ok   = 1'b0;
    addr = 32'h0;
    for (int i = 0; i < 40; i++) begin
      if (bus.imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) return;
    addr = bus.imem_addr;
    repeat (lat) @(negedge clk);
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = word;
    sb.push_back('{pc: exp_pc, word: word});
    @(negedge clk);
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'h0;
  endtask

  task automatic retire(input logic sel, input logic lden);
    instr_done = 1'b1;
    PC_sel     = sel;
    PC_lden    = lden;
    @(negedge clk);
    instr_done = 1'b0;
    PC_sel     = ~sel;
    PC_lden    = ~lden;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hBAD0_BAD0;
    repeat (3) @(negedge clk);
    tests++;
    if (bus.imem_req !== 1'b0) begin
      fails++;
      $display("FAIL rst_req: got %b want 0", bus.imem_req);
    end
    reset        = 1'b0;
    bus.imem_ack = 1'b0;
    @(negedge clk);
    tests++;
    if (bus.imem_req !== 1'b1) begin
      fails++;
      $display("FAIL rel_req: got %b want 1", bus.imem_req);
    end
    tests++;
    if (bus.imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL rel_addr: got %h want 0", bus.imem_addr);
    end
    tests++;
    if (instr_valid !== 1'b0 || instr !== 32'h0) begin
      fails++;
      $display("FAIL rel_instr: got %b/%h want 0/0", instr_valid, instr);
    end
    tests++;
    if (fetch_err !== 1'b0) begin
      fails++;
      $display("FAIL rel_err: got %b want 0", fetch_err);
    end
  endtask

  task automatic test_sequential();
    bit ok;
    logic [31:0] a;
    exp_t e;
    serve(32'h8000_0001, 32'h0, 0, ok, a);
    tests++;
    if (!ok || a !== 32'h0) begin
      fails++;
      $display("FAIL seq0_addr: got %b/%h want 1/0", ok, a);
    end
    pop_exp(e);
    tests++;
    if (instr_valid !== 1'b1 || instr !== e.word || pc_out !== e.pc) begin
      fails++;
      $display("FAIL seq0_instr: got %b %h %h want 1 %h %h",
               instr_valid, instr, pc_out, e.word, e.pc);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h1234_5678;
    repeat (2) @(negedge clk);
    bus.imem_ack   = 1'b0;
    tests++;
    if (instr !== 32'h8000_0001 || instr_valid !== 1'b1) begin
      fails++;
      $display("FAIL issue_hold: got %h/%b want 80000001/1", instr, instr_valid);
    end
    retire(1'b0, 1'b1);
    tests++;
    if (instr_valid !== 1'b0 || bus.imem_req !== 1'b0) begin
      fails++;
      $display("FAIL retire_drop: got v=%b r=%b want 0 0", instr_valid, bus.imem_req);
    end
    @(negedge clk);
    tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin
      fails++;
      $display("FAIL seq1_req: got %b/%h want 1/4", bus.imem_req, bus.imem_addr);
    end
    serve(32'h8000_0002, 32'h4, 3, ok, a);
    pop_exp(e);
    tests++;
    if (!ok || instr !== e.word || pc_out !== e.pc || instr_valid !== 1'b1) begin
      fails++;
      $display("FAIL seq1_instr: got %h %h %b want %h %h 1",
               instr, pc_out, instr_valid, e.word, e.pc);
    end
    retire(1'b0, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_branch();
    bit ok;
    logic [31:0] a;
    exp_t e;
    instr_done = 1'b1;
    PC_sel     = 1'b1;
    PC_lden    = 1'b1;
    @(negedge clk);
    instr_done = 1'b0;
    tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin
      fails++;
      $display("FAIL done_in_wait: got %b/%h want 1/8", bus.imem_req, bus.imem_addr);
    end
    serve(32'h0000_FFFF, 32'h8, 0, ok, a);
    pop_exp(e);
    tests++;
    if (!ok || a !== 32'h8 || instr !== e.word || pc_out !== e.pc) begin
      fails++;
      $display("FAIL br0_fetch: got %h %h %h want 8 %h %h", a, instr, pc_out, e.word, e.pc);
    end
    retire(1'b1, 1'b1);
    @(negedge clk);
    tests++;
    if (bus.imem_addr !== 32'h8) begin
      fails++;
      $display("FAIL br_neg: got %h want 8", bus.imem_addr);
    end
    serve(32'h0000_0002, 32'h8, 1, ok, a);
    pop_exp(e);
    tests++;
    if (!ok || instr !== e.word || pc_out !== e.pc) begin
      fails++;
      $display("FAIL br1_fetch: got %h %h want %h %h", instr, pc_out, e.word, e.pc);
    end
    retire(1'b1, 1'b1);
    @(negedge clk);
    tests++;
    if (bus.imem_addr !== 32'h14) begin
      fails++;
      $display("FAIL br_pos: got %h want 14", bus.imem_addr);
    end
    serve(32'h0000_0013, 32'h14, 0, ok, a);
    pop_exp(e);
    retire(1'b0, 1'b0);
    @(negedge clk);
    tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h14) begin
      fails++;
      $display("FAIL refetch: got %b/%h want 1/14", bus.imem_req, bus.imem_addr);
    end
    serve(32'h0000_0033, 32'h14, 2, ok, a);
    pop_exp(e);
    tests++;
    if (!ok || instr !== e.word || pc_out !== e.pc) begin
      fails++;
      $display("FAIL refetch_data: got %h %h want %h %h", instr, pc_out, e.word, e.pc);
    end
    retire(1'b0, 1'b1);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [31:0] a;
    exp_t e;
    @(negedge clk);
    reset          = 1'b1;
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    reset        = 1'b0;
    bus.imem_ack = 1'b0;
    tests++;
    if (bus.imem_req !== 1'b0 || instr_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_ack: got r=%b v=%b want 0 0", bus.imem_req, instr_valid);
    end
    tests++;
    if (pc_out !== 32'h0 || instr !== 32'h0) begin
      fails++;
      $display("FAIL rst_stale: got pc=%h i=%h want 0 0", pc_out, instr);
    end
    @(negedge clk);
    tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL rst_restart: got %b/%h want 1/0", bus.imem_req, bus.imem_addr);
    end
    serve(32'h0000_0093, 32'h0, 0, ok, a);
    pop_exp(e);
    tests++;
    if (!ok || instr !== e.word || pc_out !== e.pc) begin
      fails++;
      $display("FAIL rst_fetch: got %h %h want %h %h", instr, pc_out, e.word, e.pc);
    end
    instr_done = 1'b1;
    PC_lden    = 1'b1;
    PC_sel     = 1'b0;
    reset      = 1'b1;
    @(negedge clk);
    reset      = 1'b0;
    instr_done = 1'b0;
    tests++;
    if (instr_valid !== 1'b0 || pc_out !== 32'h0 || instr !== 32'h0) begin
      fails++;
      $display("FAIL rst_issue: got %b %h %h want 0 0 0", instr_valid, pc_out, instr);
    end
    @(negedge clk);
    tests++;
    if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL rst_issue_req: got %b/%h want 1/0", bus.imem_req, bus.imem_addr);
    end
  endtask

  task automatic test_timeout();
    bit ok;
    logic [31:0] a;
    exp_t e;
`ifdef FETCH_TIMEOUT_EN
    repeat (15) @(negedge clk);
    tests++;
    if (instr_valid !== 1'b0 || bus.imem_req !== 1'b1) begin
      fails++;
      $display("FAIL to_early: got v=%b r=%b want 0 1", instr_valid, bus.imem_req);
    end
    @(negedge clk);
    tests++;
    if (instr_valid !== 1'b1 || instr !== 32'h0 || fetch_err !== 1'b1) begin
      fails++;
      $display("FAIL to_fire: got %b %h %b want 1 0 1", instr_valid, instr, fetch_err);
    end
    tests++;
    if (bus.imem_req !== 1'b0) begin
      fails++;
      $display("FAIL to_req: got %b want 0", bus.imem_req);
    end
    retire(1'b0, 1'b1);
    @(negedge clk);
    serve(32'h0000_0013, 32'h4, 2, ok, a);
    pop_exp(e);
    tests++;
    if (!ok || a !== 32'h4 || instr !== e.word || fetch_err !== 1'b1) begin
      fails++;
      $display("FAIL to_sticky: got %h %h %b want 4 %h 1", a, instr, fetch_err, e.word);
    end
`else
    repeat (40) @(negedge clk);
    tests++;
    if (bus.imem_req !== 1'b1 || instr_valid !== 1'b0 || fetch_err !== 1'b0) begin
      fails++;
      $display("FAIL wait_hold: got %b %b %b want 1 0 0",
               bus.imem_req, instr_valid, fetch_err);
    end
    serve(32'h0000_0013, 32'h0, 0, ok, a);
    pop_exp(e);
    tests++;
    if (!ok || a !== 32'h0 || instr !== e.word || fetch_err !== 1'b0) begin
      fails++;
      $display("FAIL wait_late: got %h %h %b want 0 %h 0", a, instr, fetch_err, e.word);
    end
`endif
    retire(1'b0, 1'b1);
  endtask

  task automatic test_wrap();
    exp_t e;
    w_reset = 1'b1;
    repeat (2) @(negedge clk);
    w_reset = 1'b0;
    @(negedge clk);
    tests++;
    if (wbus.imem_req !== 1'b1 || wbus.imem_addr !== 32'hFFFF_FFFC) begin
      fails++;
      $display("FAIL wrap_rst: got %b/%h want 1/fffffffc", wbus.imem_req, wbus.imem_addr);
    end
    wbus.imem_ack   = 1'b1;
    wbus.imem_rdata = 32'h0000_0013;
    sb.push_back('{pc: 32'hFFFF_FFFC, word: 32'h0000_0013});
    @(negedge clk);
    wbus.imem_ack = 1'b0;
    pop_exp(e);
    tests++;
    if (w_valid !== 1'b1 || w_instr !== e.word || w_pc !== e.pc) begin
      fails++;
      $display("FAIL wrap_f0: got %b %h %h want 1 %h %h", w_valid, w_instr, w_pc, e.word, e.pc);
    end
    w_done = 1'b1;
    w_lden = 1'b0;
    w_sel  = 1'b1;
    @(negedge clk);
    w_done = 1'b0;
    @(negedge clk);
    tests++;
    if (wbus.imem_req !== 1'b1 || wbus.imem_addr !== 32'hFFFF_FFFC) begin
      fails++;
      $display("FAIL wrap_refetch: got %b/%h want 1/fffffffc", wbus.imem_req, wbus.imem_addr);
    end
    wbus.imem_ack   = 1'b1;
    wbus.imem_rdata = 32'h0000_006F;
    sb.push_back('{pc: 32'hFFFF_FFFC, word: 32'h0000_006F});
    @(negedge clk);
    wbus.imem_ack = 1'b0;
    pop_exp(e);
    tests++;
    if (w_instr !== e.word || w_pc !== e.pc) begin
      fails++;
      $display("FAIL wrap_f1: got %h %h want %h %h", w_instr, w_pc, e.word, e.pc);
    end
    w_done = 1'b1;
    w_lden = 1'b1;
    w_sel  = 1'b0;
    @(negedge clk);
    w_done = 1'b0;
    w_lden = 1'b0;
    tests++;
    if (w_pc !== 32'h0 || w_valid !== 1'b0) begin
      fails++;
      $display("FAIL wrap_pc: got %h/%b want 0/0", w_pc, w_valid);
    end
    @(negedge clk);
    tests++;
    if (wbus.imem_req !== 1'b1 || wbus.imem_addr !== 32'h0) begin
      fails++;
      $display("FAIL wrap_addr: got %b/%h want 1/0", wbus.imem_req, wbus.imem_addr);
    end
  endtask

  initial begin
    reset           = 1'b1;
    PC_sel          = 1'b0;
    PC_lden         = 1'b0;
    instr_done      = 1'b0;
    bus.imem_ack    = 1'b0;
    bus.imem_rdata  = 32'h0;
    w_reset         = 1'b1;
    w_sel           = 1'b0;
    w_lden          = 1'b0;
    w_done          = 1'b0;
    wbus.imem_ack   = 1'b0;
    wbus.imem_rdata = 32'h0;
    test_reset();
    test_sequential();
    test_branch();
    test_reset_mid();
    test_timeout();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
